multicycle_cpu: RTL and testbench
=================================

Name: multicycle_cpu

Overview:
- Parametrised successor to the team's 4-register, ADD/SUB/LOAD_R/STORE_R multi-cycle CPU.
- Configurable data width, register count, data-memory depth and instruction width.
- Adds a valid/ready instruction handshake, a done pulse, an expanded opcode set, zero/carry flags and illegal-opcode detection.
- Holds the register file and an internal data memory.
- Fed by the instruction sequencer or a testbench; the register file is exported for observation.

Parameters:
- DATA_WIDTH, 8, register and memory word width (>=4)
- NUM_REGS, 4, register count; power of two, >=2; REG_BITS = clog2(NUM_REGS)
- ADDR_BITS, 5, data memory has 2^ADDR_BITS words
- INSTR_WIDTH, 20, instruction width; must be >= 4 + 3*REG_BITS + DATA_WIDTH

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  INSTR_WIDTH  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  CPU can accept an instruction
- done  out  1  one-cycle pulse when an instruction retires
- busy  out  1  an instruction is in flight
- illegal  out  1  sticky flag: an illegal opcode was seen
- zero  out  1  zero flag
- carry  out  1  carry/borrow flag
- out  out  NUM_REGS*DATA_WIDTH  register file, flattened; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Instruction layout, MSB-aligned:
  - op = [W-1 -: 4]
  - X1, X2, X3 follow, REG_BITS each
  - imm = next DATA_WIDTH bits
  - remaining low bits are reserved and ignored
  - Default layout: op[19:16] X1[15:14] X2[13:12] X3[11:10] imm[9:2].
- Opcodes:
  - 0 ADD: X1 = X2 + X3
  - 1 SUB: X1 = X2 - X3
  - 2 LOAD: X1 = DMEM[X2 + imm]
  - 3 STORE: DMEM[X2 + imm] = X1
  - 4 AND, 5 OR, 6 XOR: X1 = X2 op X3
  - 7 ADDI: X1 = X2 + imm
  - 8 SHL: X1 = X2 << imm[2:0]
  - 9-15: illegal
- Reset:
  - Register i = i mod 2^DATA_WIDTH; all DMEM words = 0.
  - State = IDLE; instr_ready = 1; done, busy, illegal, zero and carry = 0.
- FSM: IDLE -> DECODE -> EXEC -> (MEM for LOAD/STORE only) -> WB -> IDLE.
- Accept: when instr_valid && instr_ready in IDLE. The instruction is latched on that edge.
- instr_ready is 1 only in IDLE. instr_valid outside IDLE is ignored; the source must hold it.
- DECODE: operands X1, X2 and X3 are read and latched, so X1 == X2 aliasing is safe.
- Latency from the accept edge to the done pulse:
  - 3 cycles for ALU ops (done asserted in WB)
  - 4 cycles for LOAD and STORE
- Throughput: the next accept is possible in the cycle after WB.
- busy = 1 in DECODE, EXEC, MEM and WB.
- Arithmetic:
  - All arithmetic is modulo 2^DATA_WIDTH.
  - Memory address = (X2 + imm) truncated to ADDR_BITS; it wraps, with no error.
- Flags:
  - ALU ops and LOAD update zero = (result == 0).
  - ADD and ADDI set carry = carry-out; SUB sets carry = borrow (X2 < X3).
  - Logic ops, SHL and LOAD clear carry.
  - STORE leaves both flags unchanged.
- Illegal opcode: goes through DECODE -> WB with no register, memory or flag write. done still pulses and illegal sets. illegal is cleared only by rst.
- Reset mid-instruction: aborts with no writeback or store; full reset values apply on the next cycle.
- No forwarding hazards exist, since only one instruction is in flight.

Optional Feature:
- Macro: CPU_MUL_EN
- Defined: opcode 9 = MUL, X1 = low DATA_WIDTH bits of X2*X3, 3-cycle latency. carry = 1 if the high half is nonzero; zero = (low half == 0).
- Undefined: opcode 9 is illegal, as described above.

Decomposition:
- Package multicycle_cpu_pkg holds:
  - the opcode enum (4-bit)
  - the FSM state enum
  - localparams OP_W = 4 and the field-offset functions of (INSTR_WIDTH, REG_BITS)
- Sub-module cpu_alu: combinational; inputs op, a, b, imm; outputs result, carry_out, zero. It is instantiated once.
- Register file, DMEM and the FSM live in multicycle_cpu.

Test Plan (defaults: DATA_WIDTH=8, NUM_REGS=4, ADDR_BITS=5, INSTR_WIDTH=20):
- Reset held for 2 edges -> out = {3,2,1,0}, instr_ready = 1, all flags 0.
- ADD r0 = r1 + r3 (20'b0000_00_01_11_00000000_00) -> r0 = 4; done exactly 3 cycles after accept; zero = 0, carry = 0.
- From reset, SUB r1 = r1 - r3 -> r1 = 0xFE, carry = 1. Then ADDI r2 = r2 + 0xFE -> r2 = 0x00, zero = 1, carry = 1.
- Memory sequence from reset:
  - STORE r3 to DMEM[r2 + 15 = 17] -> DMEM[17] = 3.
  - LOAD r0 = DMEM[r1 + 16] -> r0 = 3; 4-cycle latency each.
  - LOAD r0 = DMEM[r3 + 30] -> address wraps to 1 -> r0 = 0, zero = 1.
- Handshake: instr_valid held high continuously with two ADDs.
  - The second ADD is accepted only in the cycle after the first one's WB.
  - instr_ready is low during DECODE through WB.
- Error and abort cases:
  - Opcode 12 -> no state change, done pulses, illegal = 1 (sticky).
  - rst asserted during EXEC of an ADD -> no writeback; register file returns to {3,2,1,0}.
  - Opcode 9 also checks illegal=1 when CPU_MUL_EN is undefined.
  - With CPU_MUL_EN defined: MUL r0 = r3*r3 gives r0 = 9. After ADDI r1 = r1 + 0x0F (r1 = 16), MUL r0 = r1*r1 gives r0 = 0, carry = 1, zero = 1.

Source files
------------

// File: rtl/multicycle_cpu_pkg.sv
// Shared opcode/state types and instruction-field offset helpers for multicycle_cpu.
package multicycle_cpu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_LOAD  = 4'd2,
    OP_STORE = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_ADDI  = 4'd7,
    OP_SHL   = 4'd8,
    OP_MUL   = 4'd9
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

  // Fields are MSB-aligned: op, X1, X2, X3, then imm directly below X3.
  function automatic int op_lsb(input int instr_width);
    return instr_width - OP_W;
  endfunction

  function automatic int x1_lsb(input int instr_width, input int reg_bits);
    return instr_width - OP_W - reg_bits;
  endfunction

  function automatic int x2_lsb(input int instr_width, input int reg_bits);
    return instr_width - OP_W - 2 * reg_bits;
  endfunction

  function automatic int x3_lsb(input int instr_width, input int reg_bits);
    return instr_width - OP_W - 3 * reg_bits;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for multicycle_cpu; also forms X2+imm as the LOAD/STORE address.
// With CPU_MUL_EN defined, opcode 9 yields the low half of a*b and flags a nonzero high half.
module cpu_alu
  import multicycle_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [OP_W-1:0]       op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  zero
);

  logic [DATA_WIDTH:0] sum;
`ifdef CPU_MUL_EN
  logic [2*DATA_WIDTH-1:0] prod;
`endif

  always_comb begin
    sum       = '0;
    result    = '0;
    carry_out = 1'b0;
`ifdef CPU_MUL_EN
    prod      = '0;
`endif
    case (op)
      OP_ADD: begin
        sum       = {1'b0, a} + {1'b0, b};
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        // Top bit of the extended difference is the borrow (a < b).
        sum       = {1'b0, a} - {1'b0, b};
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
      end
      OP_LOAD, OP_STORE, OP_ADDI: begin
        sum       = {1'b0, a} + {1'b0, imm};
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = a << imm[2:0];
`ifdef CPU_MUL_EN
      OP_MUL: begin
        prod      = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        result    = prod[DATA_WIDTH-1:0];
        carry_out = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
      end
`endif
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU, IDLE->DECODE->EXEC->(MEM)->WB: done 3 cycles after accept, 4 for LOAD/STORE.
// instr_ready only in IDLE so a held instr_valid simply waits; CPU_MUL_EN enables opcode 9 = MUL.
module multicycle_cpu
  import multicycle_cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REGS    = 4,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INSTR_WIDTH-1:0]         instr,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  output logic                           done,
  output logic                           busy,
  output logic                           illegal,
  output logic                           zero,
  output logic                           carry,
  output logic [NUM_REGS*DATA_WIDTH-1:0] out
);

  localparam int REG_BITS = $clog2(NUM_REGS);
  localparam int OP_LSB   = op_lsb(INSTR_WIDTH);
  localparam int X1_LSB   = x1_lsb(INSTR_WIDTH, REG_BITS);
  localparam int X2_LSB   = x2_lsb(INSTR_WIDTH, REG_BITS);
  localparam int X3_LSB   = x3_lsb(INSTR_WIDTH, REG_BITS);
  localparam int IMM_LSB  = X3_LSB - DATA_WIDTH;
  localparam int MEM_WORDS = 2 ** ADDR_BITS;

  state_e                       state_q, state_d;
  logic [INSTR_WIDTH-1:IMM_LSB] instr_q;
  logic [DATA_WIDTH-1:0]        regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]        dmem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0]        x1v_q, x2v_q, x3v_q;
  logic [DATA_WIDTH-1:0]        res_q, mem_q;
  logic                         res_carry_q, res_zero_q;
  logic                         zero_q, carry_q, illegal_q;

  logic [OP_W-1:0]       op;
  logic [REG_BITS-1:0]   x1_idx, x2_idx, x3_idx;
  logic [DATA_WIDTH-1:0] imm;
  logic                  op_legal, op_mem;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry, alu_zero;
  logic [ADDR_BITS-1:0]  mem_addr;

  assign op       = instr_q[OP_LSB +: OP_W];
  assign x1_idx   = instr_q[X1_LSB +: REG_BITS];
  assign x2_idx   = instr_q[X2_LSB +: REG_BITS];
  assign x3_idx   = instr_q[X3_LSB +: REG_BITS];
  assign imm      = instr_q[IMM_LSB +: DATA_WIDTH];
  assign op_mem   = (op == OP_LOAD) || (op == OP_STORE);
  assign mem_addr = ADDR_BITS'(res_q);

  generate
    if (IMM_LSB > 0) begin : g_rsvd
      logic unused_rsvd;
      assign unused_rsvd = ^instr[IMM_LSB-1:0];
    end
  endgenerate

  always_comb begin
    op_legal = (op <= OP_SHL);
`ifdef CPU_MUL_EN
    if (op == OP_MUL) op_legal = 1'b1;
`endif
  end

  cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op       (op),
    .a        (x2v_q),
    .b        (x3v_q),
    .imm      (imm),
    .result   (alu_result),
    .carry_out(alu_carry),
    .zero     (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = op_legal ? ST_EXEC : ST_WB;
      ST_EXEC:   state_d = op_mem ? ST_MEM : ST_WB;
      ST_MEM:    state_d = ST_WB;
      ST_WB: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      x1v_q       <= '0;
      x2v_q       <= '0;
      x3v_q       <= '0;
      res_q       <= '0;
      mem_q       <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_WIDTH'(i);
      for (int j = 0; j < MEM_WORDS; j++) dmem_q[j] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (instr_valid) instr_q <= instr[INSTR_WIDTH-1:IMM_LSB];
        ST_DECODE: begin
          // Operands are captured here, so writing X1 later cannot disturb X2/X3.
          x1v_q <= regs_q[x1_idx];
          x2v_q <= regs_q[x2_idx];
          x3v_q <= regs_q[x3_idx];
        end
        ST_EXEC: begin
          res_q       <= alu_result;
          res_carry_q <= alu_carry;
          res_zero_q  <= alu_zero;
        end
        ST_MEM: begin
          if (op == OP_STORE) dmem_q[mem_addr] <= x1v_q;
          else                mem_q            <= dmem_q[mem_addr];
        end
        ST_WB: begin
          if (!op_legal) begin
            illegal_q <= 1'b1;
          end else if (op == OP_LOAD) begin
            regs_q[x1_idx] <= mem_q;
            zero_q         <= (mem_q == '0);
            carry_q        <= 1'b0;
          end else if (op != OP_STORE) begin
            regs_q[x1_idx] <= res_q;
            zero_q         <= res_zero_q;
            carry_q        <= res_carry_q;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
  endgenerate

  assign illegal = illegal_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu at default parameters; expected values are hand-computed.
module tb_multicycle_cpu;
  import multicycle_cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [19:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        done;
  logic        busy;
  logic        illegal;
  logic        zero;
  logic        carry;
  logic [31:0] out_w;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .done       (done),
    .busy       (busy),
    .illegal    (illegal),
    .zero       (zero),
    .carry      (carry),
    .out        (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] enc(input logic [3:0] op, input logic [1:0] x1,
                                      input logic [1:0] x2, input logic [1:0] x3,
                                      input logic [7:0] imm);
    return {op, x1, x2, x3, imm, 2'b00};
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Latency counts cycles from the accepting IDLE cycle to the cycle showing done.
  task automatic run_step(input string tag, input logic [19:0] ins, input int lat,
                          input logic [31:0] eo, input logic ez, input logic ec);
    int  n;
    bit  seen;
    instr       = ins;
    instr_valid = 1'b1;
    for (int k = 0; k < 10 && !instr_ready; k++) @(negedge clk);
    n    = 0;
    seen = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk({tag, "_lat"}, seen ? 64'(n) : 64'hDEAD, 64'(lat));
    chk({tag, "_out"}, 64'(out_w), 64'(eo));
    chk({tag, "_zc"}, 64'({zero, carry}), 64'({ez, ec}));
  endtask

  logic [8:0] rdy_seen, done_seen;

  initial begin
    rst         = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    do_reset();
    chk("rst_out", 64'(out_w), 64'h03020100);
    chk("rst_rdy", 64'(instr_ready), 64'd1);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_flags", 64'({illegal, zero, carry}), 64'd0);

    run_step("add", 20'b0000_00_01_11_00000000_00, 3, 32'h03020104, 1'b0, 1'b0);

    do_reset();
    run_step("sub",  enc(OP_SUB, 2'd1, 2'd1, 2'd3, 8'h00),  3, 32'h0302FE00, 1'b0, 1'b1);
    run_step("addi", enc(OP_ADDI, 2'd2, 2'd2, 2'd0, 8'hFE), 3, 32'h0300FE00, 1'b1, 1'b1);

    do_reset();
    run_step("addi0",     enc(OP_ADDI, 2'd0, 2'd0, 2'd0, 8'h00),  3, 32'h03020100, 1'b1, 1'b0);
    run_step("store",     enc(OP_STORE, 2'd3, 2'd2, 2'd0, 8'd15), 4, 32'h03020100, 1'b1, 1'b0);
    run_step("load",      enc(OP_LOAD, 2'd0, 2'd1, 2'd0, 8'd16),  4, 32'h03020103, 1'b0, 1'b0);
    run_step("load_wrap", enc(OP_LOAD, 2'd0, 2'd3, 2'd0, 8'd30),  4, 32'h03020100, 1'b1, 1'b0);

    do_reset();
    run_step("xor",  enc(OP_XOR, 2'd0, 2'd3, 2'd1, 8'h00), 3, 32'h03020102, 1'b0, 1'b0);
    run_step("or",   enc(OP_OR,  2'd1, 2'd1, 2'd2, 8'h00), 3, 32'h03020302, 1'b0, 1'b0);
    run_step("and",  enc(OP_AND, 2'd2, 2'd3, 2'd1, 8'h00), 3, 32'h03030302, 1'b0, 1'b0);
    run_step("shl",  enc(OP_SHL, 2'd3, 2'd3, 2'd0, 8'h0D), 3, 32'h60030302, 1'b0, 1'b0);
    run_step("add2", enc(OP_ADD, 2'd0, 2'd3, 2'd3, 8'h00), 3, 32'h600303C0, 1'b0, 1'b0);
    run_step("addc", enc(OP_ADD, 2'd0, 2'd0, 2'd3, 8'h00), 3, 32'h60030320, 1'b0, 1'b1);
    run_step("and0", enc(OP_AND, 2'd1, 2'd1, 2'd3, 8'h00), 3, 32'h60030020, 1'b1, 1'b0);

    do_reset();
    instr       = enc(OP_ADD, 2'd0, 2'd1, 2'd3, 8'h00);
    instr_valid = 1'b1;
    rdy_seen    = '0;
    done_seen   = '0;
    for (int k = 0; k < 9; k++) begin
      rdy_seen[k]  = instr_ready;
      done_seen[k] = done;
      if (k == 3) instr = enc(OP_ADD, 2'd0, 2'd0, 2'd3, 8'h00);
      if (k == 7) instr_valid = 1'b0;
      @(negedge clk);
    end
    chk("hs_ready", 64'(rdy_seen), 64'b100010001);
    chk("hs_done", 64'(done_seen), 64'b010001000);
    chk("hs_out", 64'(out_w), 64'h03020107);

    do_reset();
    run_step("zflag", enc(OP_ADDI, 2'd0, 2'd0, 2'd0, 8'h00), 3, 32'h03020100, 1'b1, 1'b0);
    run_step("ill12", enc(4'd12, 2'd0, 2'd1, 2'd3, 8'h00), 2, 32'h03020100, 1'b1, 1'b0);
    chk("ill12_flag", 64'(illegal), 64'd1);
    run_step("post_ill", enc(OP_ADD, 2'd0, 2'd1, 2'd3, 8'h00), 3, 32'h03020104, 1'b0, 1'b0);
    chk("ill_sticky", 64'(illegal), 64'd1);

    instr       = enc(OP_ADD, 2'd2, 2'd1, 2'd3, 8'h00);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", 64'(out_w), 64'h03020100);
    chk("abort_state", 64'({instr_ready, busy, done}), 64'b100);
    chk("abort_flags", 64'({illegal, zero, carry}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_late", 64'(out_w), 64'h03020100);

`ifdef CPU_MUL_EN
    run_step("mul",    enc(OP_MUL, 2'd0, 2'd3, 2'd3, 8'h00),  3, 32'h03020109, 1'b0, 1'b0);
    run_step("addi15", enc(OP_ADDI, 2'd1, 2'd1, 2'd0, 8'h0F), 3, 32'h03021009, 1'b0, 1'b0);
    run_step("mul_hi", enc(OP_MUL, 2'd0, 2'd1, 2'd1, 8'h00),  3, 32'h03021000, 1'b1, 1'b1);
    chk("mul_legal", 64'(illegal), 64'd0);
`else
    run_step("op9", enc(4'd9, 2'd0, 2'd3, 2'd3, 8'h00), 2, 32'h03020100, 1'b0, 1'b0);
    chk("op9_flag", 64'(illegal), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
